// File: rtl/fma_bypass_ctrl.sv
// FMA issue-side hazard/bypass controller: tracks in-flight destination
// tags, stalls or bypasses X/Y/Z sources and drives RF writeback.
module fma_bypass_ctrl #(
  parameter int LAT = 4,
  parameter int PRE = 3,
  parameter int RW  = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [RW-1:0] xreg,
  input  logic [RW-1:0] yreg,
  input  logic [RW-1:0] zreg,
  input  logic          xuse,
  input  logic          yuse,
  input  logic          zuse,
  input  logic [RW-1:0] dreg,
  input  logic          dwen,
  input  logic [63:0]   pre_result,
  output logic [1:0]    bypsel,
  output logic [63:0]   wbypass,
  output logic          rf_we,
  output logic [RW-1:0] rf_waddr,
  output logic          busy,
  output logic [15:0]   byp_count
);

  logic [LAT:1]         vld_q, vld_d;
  logic [LAT:1][RW-1:0] tag_q, tag_d;
  logic [15:0]          cnt_q, cnt_d;

  logic [1:0] x_res, z_res;
  logic       y_stall;
  logic       accept;

  // Youngest matching tag wins: scan oldest to youngest, last hit sticks.
  // Result is {stall, bypass}.
  function automatic logic [1:0] src_chk(
    input logic [RW-1:0]         r,
    input logic                  u,
    input logic [LAT:1]          v,
    input logic [LAT:1][RW-1:0]  t
  );
    logic [1:0] res;
    res = 2'b00;
    for (int k = LAT; k >= 1; k--) begin
      if (u && v[k] && (t[k] == r)) begin
        res[0] = (k == PRE);
        res[1] = (k != PRE) && (k != LAT);
      end
    end
    return res;
  endfunction

  always_comb begin
    x_res   = src_chk(xreg, xuse, vld_q, tag_q);
    z_res   = src_chk(zreg, zuse, vld_q, tag_q);
    y_stall = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      if (yuse && vld_q[k] && (tag_q[k] == yreg))
        y_stall = 1'b1;
    end
    issue_ready = ~flush & ~x_res[1] & ~z_res[1] & ~y_stall;
    accept      = issue_valid & issue_ready;
    bypsel      = {accept & z_res[0], accept & x_res[0]};
  end

  always_comb begin
    vld_d    = '0;
    tag_d    = tag_q;
    vld_d[1] = accept & dwen;
    tag_d[1] = dreg;
    for (int k = 2; k <= LAT; k++) begin
      vld_d[k] = vld_q[k-1] & ~flush;
      tag_d[k] = tag_q[k-1];
    end
    cnt_d = cnt_q;
    if (accept && (bypsel != 2'b00) && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end

  assign wbypass   = pre_result;
  assign rf_we     = vld_q[LAT];
  assign rf_waddr  = tag_q[LAT];
  assign busy      = |vld_q;
  assign byp_count = cnt_q;

endmodule
